// File: rtl/ascii_tx_sequencer_pkg.sv
// Shared types and constants for the ASCII transmit sequencer.
// Optional feature macro: ASCII_TX_CRLF_EN (appends CR/LF after each packet).
package ascii_tx_sequencer_pkg;

   // Sequencer states; TERM only exists when CR/LF termination is built in.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_CONV = 3'd2,
      ST_SEND      = 3'd3,
`ifdef ASCII_TX_CRLF_EN
      ST_TERM      = 3'd4,
`endif
      ST_DONE      = 3'd5
   } state_t;

   localparam int         PAYLOAD_BYTES  = 10;
   localparam int         PAYLOAD_IDX_W  = $clog2(PAYLOAD_BYTES);
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;

   // Counter must hold 0 .. timeout-1; never narrower than one bit.
   function automatic int timeout_cnt_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

   localparam int CONV_TIMEOUT_DEFAULT = 16;
   localparam int TIMEOUT_CNT_W        = timeout_cnt_width(CONV_TIMEOUT_DEFAULT);

endpackage

// File: rtl/ascii_tx_sequencer_serializer.sv
// Byte serializer: holds the ten converted ASCII bytes and streams them
// LSB byte first over a valid/ready handshake.
// Optional feature macro: ASCII_TX_CRLF_EN (adds CR then LF after payload).
module ascii_byte_serializer
   import ascii_tx_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [79:0] i_ascii,
   input  logic        i_send,
`ifdef ASCII_TX_CRLF_EN
   input  logic        i_term,
   output logic        o_term_done,
`endif
   input  logic        i_tx_ready,
   output logic        o_tx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_payload_done
);

   logic [79:0]              r_shift;
   logic [PAYLOAD_IDX_W-1:0] r_idx;
   logic                     w_payload_xfer;

   // A payload byte moves only on a handshake; otherwise data is held stable.
   assign w_payload_xfer = i_send && i_tx_ready;
   assign o_payload_done = w_payload_xfer && (r_idx == PAYLOAD_IDX_W'(PAYLOAD_BYTES - 1));

`ifdef ASCII_TX_CRLF_EN
   logic r_term_sel;   // 0 = CR pending, 1 = LF pending

   assign o_tx_valid  = i_send || i_term;
   assign o_tx_data   = i_term ? (r_term_sel ? ASCII_LF : ASCII_CR) : r_shift[7:0];
   assign o_term_done = i_term && i_tx_ready && r_term_sel;

   // Terminator byte select: toggles per accepted CR/LF byte, wraps back to CR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_term_sel <= 1'b0;
      end else if (i_load) begin
         r_term_sel <= 1'b0;
      end else if (i_term && i_tx_ready) begin
         r_term_sel <= ~r_term_sel;
      end
   end
`else
   assign o_tx_valid = i_send;
   assign o_tx_data  = r_shift[7:0];
`endif

   // Shift register and byte index: load on conversion result, shift per byte.
   // NOTE: the data register is reset too, so tx_data reads 0 out of reset
   // instead of whatever the last packet left behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (i_load) begin
         r_shift <= i_ascii;
         r_idx   <= '0;
      end else if (w_payload_xfer) begin
         r_shift <= {8'h00, r_shift[79:8]};
         r_idx   <= r_idx + PAYLOAD_IDX_W'(1);
      end
   end

endmodule

// File: rtl/ascii_tx_sequencer.sv
// ASCII transmit sequencer: accepts a 5-byte hex packet, hands it to an
// external hex-to-ASCII converter, then streams the 10 ASCII bytes to a UART.
// Optional feature macro: ASCII_TX_CRLF_EN (CR/LF appended, 12 bytes/packet).
module ascii_tx_sequencer
   import ascii_tx_sequencer_pkg::*;
#(
   parameter int CONV_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [39:0] in_data,
   output logic        conv_valid,
   output logic        conv_active,
   output logic [39:0] conv_data_out,
   input  logic        conv_ready,
   input  logic [79:0] conv_ascii,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        err_timeout
);

   localparam int CNT_W = timeout_cnt_width(CONV_TIMEOUT);

   state_t           r_state;
   logic [CNT_W-1:0] r_to_cnt;
   logic [39:0]      r_conv_data;
   logic             r_err;
   logic             w_load;
   logic             w_timeout_hit;
   logic             w_payload_done;

   // Status outputs decode straight from the state register.
   assign in_ready      = (r_state == ST_IDLE);
   assign busy          = (r_state != ST_IDLE);
   assign conv_valid    = (r_state == ST_START);
   assign conv_active   = (r_state != ST_WAIT_CONV);
   assign conv_data_out = r_conv_data;
   assign err_timeout   = r_err;

   // conv_ready wins over timeout expiry in the same cycle.
   assign w_load        = (r_state == ST_WAIT_CONV) && conv_ready;
   assign w_timeout_hit = (r_state == ST_WAIT_CONV) && !conv_ready &&
                          (r_to_cnt == CNT_W'(CONV_TIMEOUT - 1));

`ifdef ASCII_TX_CRLF_EN
   logic w_term_done;
`endif

   ascii_byte_serializer u_serializer (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_load         (w_load),
      .i_ascii        (conv_ascii),
      .i_send         (r_state == ST_SEND),
`ifdef ASCII_TX_CRLF_EN
      .i_term         (r_state == ST_TERM),
      .o_term_done    (w_term_done),
`endif
      .i_tx_ready     (tx_ready),
      .o_tx_valid     (tx_valid),
      .o_tx_data      (tx_data),
      .o_payload_done (w_payload_done)
   );

   // Main FSM with packet capture, converter timeout and error pulse.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_to_cnt    <= '0;
         r_conv_data <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_conv_data <= in_data;
                  r_state     <= ST_START;
               end
            end
            ST_START: begin
               r_to_cnt <= '0;
               r_state  <= ST_WAIT_CONV;
            end
            ST_WAIT_CONV: begin
               if (conv_ready) begin
                  r_state <= ST_SEND;
               end else if (w_timeout_hit) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + CNT_W'(1);
               end
            end
            ST_SEND: begin
               if (w_payload_done) begin
`ifdef ASCII_TX_CRLF_EN
                  r_state <= ST_TERM;
`else
                  r_state <= ST_DONE;
`endif
               end
            end
`ifdef ASCII_TX_CRLF_EN
            ST_TERM: begin
               if (w_term_done) r_state <= ST_DONE;
            end
`endif
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ascii_tx_sequencer.md
ASCII_TX_SEQUENCER -- requirements
Module: ascii_tx_sequencer

Interface
REQ-001 SHALL have parameter CONV_TIMEOUT, default 16: maximum cycles to wait for converter ready.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream packet valid.
REQ-005 SHALL have port in_ready  output  1  block idle and able to accept a packet.
REQ-006 SHALL have port in_data  input  40  five hex bytes (company, four, profit, twitter, moving).
REQ-007 SHALL have port conv_valid  output  1  one-cycle start pulse to the hex-to-ASCII converter's data_valid.
REQ-008 SHALL have port conv_active  output  1  drives the converter's active input; low only while the block waits for conversion.
REQ-009 SHALL have port conv_data_out  output  40  captured packet presented to the converter.
REQ-010 SHALL have port conv_ready  input  1  converter result valid.
REQ-011 SHALL have port conv_ascii  input  80  converter result, ten ASCII bytes.
REQ-012 SHALL have port tx_valid  output  1  UART byte valid.
REQ-013 SHALL have port tx_ready  input  1  UART able to accept a byte.
REQ-014 SHALL have port tx_data  output  8  UART byte.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port err_timeout  output  1  one-cycle pulse when the converter does not answer.

Function
REQ-017 SHALL implement states IDLE, START, WAIT_CONV, SEND, TERM, DONE.
REQ-018 in_ready SHALL equal (state==IDLE); in_data SHALL be captured into conv_data_out on the in_valid&&in_ready cycle, with transition to START.
REQ-019 START SHALL assert conv_valid for exactly one cycle, then go to WAIT_CONV, clear the timeout counter and hold conv_active low.
REQ-020 conv_active SHALL be high in all states except WAIT_CONV.
REQ-021 In WAIT_CONV, conv_ready high SHALL capture conv_ascii into an 80-bit shift register, clear the byte index to 0, and go to SEND.
REQ-022 In WAIT_CONV, if conv_ready stays low for CONV_TIMEOUT cycles, the block SHALL pulse err_timeout, send no bytes, and go to IDLE.
REQ-023 If conv_ready and timeout expiry occur in the same cycle, the block SHALL honour conv_ready and SHALL NOT pulse err_timeout.
REQ-024 In SEND, tx_valid SHALL be high and tx_data SHALL equal shift register bits [7:0]; bytes SHALL go out in ascending bit order (byte 0 = bits [7:0] first).
REQ-025 A byte SHALL transfer on a cycle with tx_valid&&tx_ready; the register then shifts right by 8 and the index increments.
REQ-026 While tx_ready is low, tx_valid and tx_data SHALL remain stable (no drop, no reorder).
REQ-027 Back-to-back tx_ready high SHALL give one byte per cycle; after byte index 9 transfers, the block SHALL go to TERM (macro defined) or DONE.
REQ-028 DONE SHALL last one cycle, then go to IDLE; the minimum packet-to-packet spacing is therefore bounded by those states.
REQ-029 in_valid while busy SHALL be ignored (in_ready low); conv_ready outside WAIT_CONV SHALL be ignored.

Reset
REQ-030 While rst_n is low, the block SHALL go to IDLE immediately, including in the middle of a packet; the partial packet is discarded.
REQ-031 Reset values SHALL be: in_ready=1, conv_valid=0, conv_active=1, conv_data_out=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0, and shift register, index and timeout counter all 0.

Configuration
REQ-032 With ASCII_TX_CRLF_EN defined, TERM SHALL send 8'h0D then 8'h0A under the same handshake as REQ-025/026, then go to DONE; 12 bytes per packet.
REQ-033 Without ASCII_TX_CRLF_EN, the TERM state and its logic SHALL be absent; 10 bytes per packet.

Structure
REQ-034 A shared package SHALL hold: the state enum, PAYLOAD_BYTES=10, ASCII_CR=8'h0D, ASCII_LF=8'h0A, and the timeout counter width derived from CONV_TIMEOUT.
REQ-035 The converter SHALL remain external; one sub-module, ascii_byte_serializer (shift register, index and tx handshake), is natural.

Verification
REQ-036 Scenario 1: in_data=40'h0123456789 with a behavioural converter and tx_ready tied high -> tx_data sequence "8","9","6","7","4","5","2","3","0","1" on 10 consecutive cycles.
REQ-037 Scenario 2: tx_ready toggling 1010... -> same 10 bytes, each held stable while tx_ready=0.
REQ-038 Scenario 3: converter never asserts conv_ready -> err_timeout pulses exactly 16 cycles after WAIT_CONV is entered, tx_valid never rises, and in_ready returns high.
REQ-039 Scenario 4: rst_n dropped after byte 4 -> all outputs take reset values asynchronously; a fresh packet after release sends 10 complete bytes.
REQ-040 Scenario 5: ASCII_TX_CRLF_EN defined, in_data=40'hFFFFFFFFFF -> ten "F" bytes, then 8'h0D and 8'h0A; a second in_valid asserted mid-packet is not accepted.
